// File: rtl/fetch_unit.sv
// Instruction fetch PC sequencer with branch/call/return and an optional return-address stack.
// Define FETCH_RETURN_STACK_EN to build the return stack; without it call is a plain jump and ret is sequential.
module fetch_unit #(
    parameter int         STACK_DEPTH = 4,
    parameter logic [7:0] RESET_PC    = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       branch,
    input  logic       branch_taken,
    input  logic [7:0] jump_offset,
    input  logic       call,
    input  logic       ret,
    output logic [7:0] pc,
    output logic       pc_valid,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    logic [7:0] pc_q, pc_d;
    logic       pc_valid_q;
    logic [7:0] pc_seq, pc_tgt;

    // 8-bit add of the offset is the sign-extended add modulo 256.
    assign pc_seq = pc_q + 8'd1;
    assign pc_tgt = pc_q + jump_offset;

`ifdef FETCH_RETURN_STACK_EN
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [7:0]    stack_q [STACK_DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          push;
    logic          full, empty;
    logic [IW-1:0] push_idx, top_idx;

    assign full     = (cnt_q == CW'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);
    assign push_idx = IW'(cnt_q);
    assign top_idx  = IW'(cnt_q - 1'b1);

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!empty) begin
                pc_d  = stack_q[top_idx];
                cnt_d = cnt_q - 1'b1;
            end else begin
                pc_d  = pc_seq;
                err_d = 1'b1;
            end
        end else if (call) begin
            if (!full) begin
                push  = 1'b1;
                pc_d  = pc_tgt;
                cnt_d = cnt_q + 1'b1;
            end else begin
                pc_d  = pc_seq;
                err_d = 1'b1;
            end
        end else if (branch && branch_taken) begin
            pc_d = pc_tgt;
        end else begin
            pc_d = pc_seq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entries are not reset; a zero count makes stale contents unreachable.
    always_ff @(posedge clk) begin
        if (push) stack_q[push_idx] <= pc_seq;
    end

    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (stall)                       pc_d = pc_q;
        else if (ret)                    pc_d = pc_seq;
        else if (call)                   pc_d = pc_tgt;
        else if (branch && branch_taken) pc_d = pc_tgt;
        else                             pc_d = pc_seq;
    end

    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= 1'b1;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = pc_valid_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter STACK_DEPTH, default 4, sets the number of return-address entries (2..16).
REQ-002 Parameter RESET_PC, default 8'h00, sets the PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hold PC and stack this cycle.
REQ-006 branch  input  1  current instruction is a conditional branch.
REQ-007 branch_taken  input  1  branch condition is true; ignored unless branch=1.
REQ-008 jump_offset  input  8  signed two's-complement offset, relative to the current PC.
REQ-009 call  input  1  subroutine call: push return address, jump by offset.
REQ-010 ret  input  1  subroutine return: pop return address into PC.
REQ-011 pc  output  8  instruction address driven to instruction memory (registered).
REQ-012 pc_valid  output  1  pc holds a fetched address (registered).
REQ-013 stack_full  output  1  return stack holds STACK_DEPTH entries (combinational from count).
REQ-014 stack_empty  output  1  return stack holds 0 entries (combinational from count).
REQ-015 stack_err  output  1  sticky overflow/underflow flag (registered).

Function
REQ-016 Next-PC priority per cycle SHALL be: stall > ret > call > (branch & branch_taken) > sequential.
REQ-017 stall=1: pc, stack contents, count and stack_err SHALL be unchanged.
REQ-018 Sequential: pc <= pc + 1, modulo 256 (8'hFF wraps to 8'h00).
REQ-019 Taken branch: pc <= pc + jump_offset, with the offset sign-extended and the result modulo 256.
REQ-020 Not-taken branch (branch=1, branch_taken=0) SHALL behave as sequential.
REQ-021 Call, stack not full: push pc+1 (mod 256), pc <= pc + jump_offset, count increments; pushed value is visible to a ret in the next cycle.
REQ-022 Call, stack full: no push, pc <= pc + 1, stack_err <= 1.
REQ-023 Ret, stack not empty: pc <= top entry, count decrements.
REQ-024 Ret, stack empty: pc <= pc + 1, stack_err <= 1.
REQ-025 call and ret both asserted: ret SHALL win and call SHALL be ignored entirely (no push).
REQ-026 branch asserted together with call or ret SHALL be ignored.
REQ-027 stack_err SHALL remain 1 until reset once set.
REQ-028 pc_valid SHALL be 0 in reset and SHALL become 1 at the first posedge clk after rst_n deasserts, then stay 1; stall does not clear it.
REQ-029 Latency: every pc update SHALL take exactly one clock; pc SHALL have no combinational path from any input.

Reset
REQ-030 rst_n=0 SHALL immediately, without a clock, force pc=RESET_PC, pc_valid=0, stack count=0, stack_err=0.
REQ-031 Reset mid-operation SHALL discard any in-flight call/ret; stack entry contents need not be cleared, but SHALL be unreachable while count=0.
REQ-032 Outputs after reset SHALL be stack_empty=1 and stack_full=0.

Configuration
REQ-033 Macro FETCH_RETURN_STACK_EN defined: the return stack SHALL be present as specified above.
REQ-034 Macro FETCH_RETURN_STACK_EN undefined: no stack storage; call SHALL act as an unconditional taken branch with no push; ret SHALL act as sequential; stack_full=0, stack_empty=1, stack_err=0 constantly.

Verification
REQ-035 Reset release with RESET_PC=8'h00 and no controls -> pc steps 00,01,02,…; pc_valid=1 from the first edge.
REQ-036 pc=8'h10, branch=1, branch_taken=1, offset=8'hFC -> pc=8'h0C; with branch_taken=0 -> pc=8'h11; pc=8'hFF sequential -> 8'h00.
REQ-037 pc=8'h20, call with offset 8'h10 -> pc=8'h30, stack_empty=0; next cycle ret -> pc=8'h21, stack_empty=1.
REQ-038 STACK_DEPTH=4: five calls -> stack_full=1 after the 4th; the 5th gives pc+1 and stack_err=1; four rets then unwind in LIFO order.
REQ-039 Empty stack, ret -> pc+1 and stack_err=1; stall=1 with call -> pc and count unchanged; call+ret together -> pop only.
REQ-040 rst_n pulsed low asynchronously between edges during a call sequence -> pc=RESET_PC at once, stack_empty=1, stack_err=0.
